// File: rtl/rr_onehot_arbiter_pkg.sv
// arb_pkg: shared types and the round-robin pick helper for rr_onehot_arbiter.
//   arb_state_t : IDLE (no grant outstanding) / BUSY (one requester owns the mux)
//   rr_pick     : one-hot pick of the first requester after ptr, wrapping mod n
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  // The helper works on a fixed maximum width so it can serve any N up to 32;
  // callers cast their vectors in and truncate the result back to N bits.
  localparam int ARB_MAX_N = 32;
  localparam int ARB_PTR_W = $clog2(ARB_MAX_N);
  localparam int ARB_CNT_W = ARB_PTR_W + 1;

  // Scan ptr+1, ptr+2, ... (mod n) and return the first requester as one-hot.
  // ptr < n and k <= n, so a single conditional subtract replaces the modulo.
  function automatic logic [ARB_MAX_N-1:0] rr_pick(
    input logic [ARB_MAX_N-1:0] req,
    input logic [ARB_CNT_W-1:0] n,
    input logic [ARB_PTR_W-1:0] ptr
  );
    logic [ARB_MAX_N-1:0] g;
    logic                 found;
    logic [ARB_CNT_W-1:0] idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= ARB_MAX_N; k++) begin
      idx = ARB_CNT_W'(ptr) + ARB_CNT_W'(k);
      if (idx >= n) idx = idx - n;
      if ((ARB_CNT_W'(k) <= n) && !found && req[idx[ARB_PTR_W-1:0]]) begin
        g[idx[ARB_PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Requester/downstream bundle for rr_onehot_arbiter.
//   req/last/idata : per-requester request, end-of-burst flag and data
//   grant          : registered one-hot grant (mux select), 0 = idle
//   odata/ovalid   : forwarded data of the granted requester
//   oready         : downstream accept
// master = requesters + downstream side, slave = the arbiter.
interface rr_onehot_arbiter_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic [N-1:0]        req;
  logic [N-1:0]        last;
  logic [N-1:0][W-1:0] idata;
  logic [N-1:0]        grant;
  logic [W-1:0]        odata;
  logic                ovalid;
  logic                oready;

  modport master (output req, last, idata, oready, input grant, odata, ovalid);
  modport slave  (input req, last, idata, oready, output grant, odata, ovalid);
endinterface

// File: rtl/rr_onehot_arbiter_mux.sv
// onehot_mux: N-input AND-OR data mux driven by a one-hot (or zero) select.
//   sel   : one-hot select, all-zero yields odata = 0
//   idata : N words of W bits
//   odata : OR of the selected words
module onehot_mux #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] idata,
  output logic [W-1:0]        odata
);
  always_comb begin
    odata = '0;
    for (int i = 0; i < N; i++) odata |= idata[i] & {W{sel[i]}};
  end
endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter sharing one N-input one-hot mux.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rr_onehot_arbiter_if slave (req/last/idata in, grant/odata/ovalid out,
//                oready in)
// A grant is held for a burst until last, withdrawal, or MAX_HOLD transfers, then
// dropped for one idle cycle before the next pick. ptr remembers the last owner so
// it ranks lowest in the next pick.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_onehot_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [N-1:0]  pick;
  logic [PW-1:0] gidx;
  logic [HW-1:0] hold_cnt_inc;
  logic          req_g, last_g, xfer;

  assign pick   = N'(rr_pick(ARB_MAX_N'(bus.req), ARB_CNT_W'(N), ARB_PTR_W'(ptr_q)));
  assign req_g  = |(grant_q & bus.req);
  assign last_g = |(grant_q & bus.last);
  assign xfer   = req_g & bus.oready;

  // Index of the current owner, used to update ptr on release.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) if (grant_q[i]) gidx = PW'(i);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    hold_cnt_inc = hold_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d    = pick;
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (!req_g) begin
          // Withdrawal: no transfer this cycle, just release.
          grant_d = '0;
          ptr_d   = gidx;
          state_d = IDLE;
        end else if (xfer) begin
          hold_cnt_d = hold_cnt_inc;
          if (last_g || hold_cnt_inc == HW'(MAX_HOLD)) begin
            grant_d = '0;
            ptr_d   = gidx;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= PW'(N - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.ovalid = req_g;

  onehot_mux #(.N(N), .W(W)) u_mux (
    .sel   (grant_q),
    .idata (bus.idata),
    .odata (bus.odata)
  );

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
module tb_rr_onehot_arbiter;
  localparam int N        = 4;
  localparam int W        = 2;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_onehot_arbiter_if #(.N(N), .W(W)) bus ();

  rr_onehot_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [N-1:0] grant;
    logic [W-1:0] odata;
    logic         ovalid;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: owner index (-1 = none), last owner, transfers in this burst.
  int m_cur, m_ptr, m_cnt;

  function automatic void model_reset();
    m_cur = -1;
    m_ptr = N - 1;
    m_cnt = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.grant  = '0;
    e.odata  = '0;
    e.ovalid = 1'b0;
    if (m_cur >= 0) begin
      e.grant  = N'(1) << m_cur;
      e.ovalid = bus.req[m_cur];
      e.odata  = bus.idata[m_cur];
    end
    return e;
  endfunction

  function automatic void model_step();
    if (m_cur < 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_cur < 0 && bus.req[i]) begin
          m_cur = i;
          m_cnt = 0;
        end
      end
    end else if (!bus.req[m_cur]) begin
      m_ptr = m_cur;
      m_cur = -1;
    end else if (bus.oready) begin
      m_cnt++;
      if (bus.last[m_cur] || m_cnt == MAX_HOLD) begin
        m_ptr = m_cur;
        m_cur = -1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: called at a negedge, returns the grant seen during this cycle.
  task automatic cyc(input logic rstv, input logic [N-1:0] r, input logic [N-1:0] l,
                     input logic rdy, output logic [N-1:0] g);
    rst_n = rstv;
    if (!rstv) model_reset();
    bus.req    = r;
    bus.last   = l;
    bus.oready = rdy;
    for (int i = 0; i < N; i++) bus.idata[i] = W'($urandom);
    #1;
    exp_q.push_back(model_out());
    g = bus.grant;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  // Monitor: compares everything the DUT presents against the queued expectations.
  always @(negedge clk) begin
    exp_t e;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant",  32'(bus.grant),  32'(e.grant));
      check("ovalid", 32'(bus.ovalid), 32'(e.ovalid));
      check("odata",  32'(bus.odata),  32'(e.odata));
    end
  end

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] gs[12];
    logic [N-1:0] rr_exp[10];
    logic [N-1:0] r;
    logic [N-1:0] drop;
    rr_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
               4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    model_reset();
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.last   = '0;
    bus.oready = 1'b0;
    bus.idata  = '0;
    @(negedge clk);

    // Reset with everyone requesting
    cyc(1'b0, 4'b1111, 4'b0000, 1'b1, g);
    check("rst_grant",  32'(g), 0);
    check("rst_ovalid", 32'(bus.ovalid), 0);
    check("rst_odata",  32'(bus.odata), 0);

    // Round-robin after release; first grant goes to req0
    for (int k = 0; k < 10; k++) cyc(1'b1, 4'b1111, 4'b1111, 1'b1, gs[k]);
    for (int k = 0; k < 10; k++) check($sformatf("rr_%0d", k), 32'(gs[k]), 32'(rr_exp[k]));

    // Single burst of 3 from req2
    cyc(1'b1, 4'b0000, 4'b0000, 1'b1, g);
    cyc(1'b1, 4'b0000, 4'b0000, 1'b1, g);
    for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0100, 4'b0000, 1'b1, gs[k]);
    cyc(1'b1, 4'b0100, 4'b0100, 1'b1, gs[3]);
    cyc(1'b1, 4'b0000, 4'b0000, 1'b1, gs[4]);
    check("burst_g1", 32'(gs[1]), 32'h4);
    check("burst_g3", 32'(gs[3]), 32'h4);
    check("burst_idle", 32'(gs[4]), 0);

    // Hold limit: req0 gets exactly MAX_HOLD transfers
    cyc(1'b1, 4'b0000, 4'b0000, 1'b1, g);
    for (int k = 0; k < 11; k++) cyc(1'b1, 4'b0011, 4'b0000, 1'b1, gs[k]);
    check("hold_g1", 32'(gs[1]), 32'h1);
    check("hold_g8", 32'(gs[8]), 32'h1);
    check("hold_idle", 32'(gs[9]), 0);
    check("hold_next", 32'(gs[10]), 32'h2);

    // Back-pressure then withdrawal
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0, g);
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0, g);
    for (int k = 0; k < 6; k++) cyc(1'b1, 4'b0001, 4'b0000, 1'b0, gs[k]);
    check("bp_held", 32'(gs[5]), 32'h1);
    check("bp_cnt", 32'(dut.hold_cnt_q), 0);
    cyc(1'b1, 4'b0010, 4'b0000, 1'b1, gs[6]);
    cyc(1'b1, 4'b0010, 4'b0000, 1'b1, gs[7]);
    cyc(1'b1, 4'b0010, 4'b0010, 1'b1, gs[8]);
    check("wd_idle", 32'(gs[7]), 0);
    check("wd_next", 32'(gs[8]), 32'h2);

    // Mid-burst reset after 3 transfers
    cyc(1'b1, 4'b0000, 4'b0000, 1'b1, g);
    for (int k = 0; k < 4; k++) cyc(1'b1, 4'b0100, 4'b0000, 1'b1, gs[k]);
    check("mid_cnt", 32'(dut.hold_cnt_q), 3);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, g);
    check("mid_rst_grant", 32'(g), 0);
    for (int k = 0; k < 11; k++) cyc(1'b1, 4'b1000, 4'b0000, 1'b1, gs[k]);
    check("post_rst_g1", 32'(gs[1]), 32'h8);
    check("post_rst_g8", 32'(gs[8]), 32'h8);
    check("post_rst_idle", 32'(gs[9]), 0);

    // Randomized traffic with sticky requests and rare resets
    r = '0;
    for (int k = 0; k < 2000; k++) begin
      drop = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      r    = (r & ~drop) | (N'($urandom) & N'($urandom));
      cyc($urandom_range(0, 299) != 0, r, N'($urandom) & N'($urandom) & N'($urandom),
          $urandom_range(0, 3) != 0, g);
    end

    cyc(1'b1, 4'b0000, 4'b0000, 1'b1, g);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
